ext_arbiter: RTL and testbench
==============================

Name: ext_arbiter

Overview:
- Shares one immediate extend unit between two requesters: requester 0 is the decode-stage ALU immediate path, requester 1 is the branch-offset path.
- Round-robin arbitration; at most one grant per cycle.
- Registered single-entry output with valid/ready backpressure and a requester tag.
- Sits between decode and the ALU / branch adder in the 32-bit datapath.

Parameters:
- N, 16, immediate width in bits; legal range 1..31.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request; held with its data until granted
- ext_op0  input  1  requester 0 mode: 0 = zero-extend, 1 = sign-extend
- imm0  input  N  requester 0 immediate
- req1  input  1  requester 1 request; held with its data until granted
- ext_op1  input  1  requester 1 mode
- imm1  input  N  requester 1 immediate
- gnt0  output  1  combinational grant to requester 0 (accepted this cycle)
- gnt1  output  1  combinational grant to requester 1
- out_valid  output  1  output register holds a result
- out_id  output  1  requester that owns the result (0 or 1)
- out  output  32  extended immediate
- out_ready  input  1  consumer accepts the result when out_valid is high

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: out_valid=0, out_id=0, out=0, last_gnt=1 (so requester 0 wins the first contested cycle).
- gnt0 and gnt1 are 0 while reset is high.
- can_accept = !out_valid | out_ready (output slot empty, or emptying this cycle).
- Grants, only when can_accept:
  - only req0 -> gnt0
  - only req1 -> gnt1
  - both -> grant the requester != last_gnt
- gnt0 and gnt1 are mutually exclusive and never asserted when can_accept=0.
- On a grant at edge k:
  - out <= extend(ext_op_g, imm_g); out_id <= granted index
  - out_valid <= 1; last_gnt <= granted index
  - Latency: request to out_valid is 1 cycle.
- Extend rule:
  - upper 32-N bits = 1 iff ext_op=1 and imm[N-1]=1, else 0
  - lower N bits = imm unchanged
- Output transfer: out_valid & out_ready. With no new grant, out_valid <= 0 and out/out_id hold their last values.
- Simultaneous transfer and grant: the new result replaces the old in the same edge; out_valid stays 1. Throughput is 1 result per cycle.
- Backpressure: out_valid=1 & out_ready=0 -> no grants; out, out_id and last_gnt are frozen.
- Requester rules:
  - A requester may drop req without a grant. No result is produced for it.
  - A requester must not change imm or ext_op while req is high and ungranted. The block does not check this.
- Reset mid-operation: the pending result is discarded (out_valid=0), the round-robin pointer returns to 1, and no grant is issued in the reset cycle.
- State machine, implicit in out_valid:
  - EMPTY -> FULL on grant
  - FULL -> EMPTY on transfer without grant
  - FULL -> FULL on transfer with grant, or on stall

Decomposition:
- Shared package/header:
  - REQ_ALU=0, REQ_BR=1
  - EXT_ZERO=0, EXT_SIGN=1
  - default N=16
- Sub-module: instantiate the existing extend unit (ext_op, in, out; parameter n=N) once.
  - Feed it from a 2:1 mux on {ext_op, imm} selected by gnt1.
  - Register its output.
- Arbitration logic stays inline.

Test Plan:
- Reset then req0=1, ext_op0=1, imm0=0x8000, out_ready=1 -> gnt0=1 same cycle; next cycle out_valid=1, out_id=0, out=0xFFFF8000.
- req1 only, ext_op1=0, imm1=0x8000 -> gnt1; next cycle out=0x00008000, out_id=1.
- req0 and req1 held high for 4 cycles, out_ready=1:
  - grants alternate 0,1,0,1 starting with 0
  - outputs back-to-back, out_valid continuously 1
- out_valid=1 with out_ready=0 for 3 cycles while req0=1:
  - gnt0=0 throughout; out stable
  - on out_ready=1, gnt0 fires the same cycle and the new result appears next cycle
- Sign boundary: ext_op=1, imm=0x7FFF -> 0x00007FFF; imm=0xFFFF -> 0xFFFFFFFF; ext_op=0, imm=0xFFFF -> 0x0000FFFF. Repeat with N=8: imm=0x80, ext_op=1 -> 0xFFFFFF80.
- Assert reset while out_valid=1 and both req high:
  - next cycle out_valid=0, no grants during reset
  - first post-reset contested cycle grants requester 0

Source files
------------

// File: rtl/ext_arbiter_pkg.sv
// Shared constants for the immediate-extend arbiter.
// Requester indices, extend modes and default width.
package ext_arbiter_pkg;

  localparam int   N_DEFAULT = 16;

  localparam logic REQ_ALU   = 1'b0;
  localparam logic REQ_BR    = 1'b1;

  localparam logic EXT_ZERO  = 1'b0;
  localparam logic EXT_SIGN  = 1'b1;

  // Reset value of the round-robin pointer so the ALU path wins first.
  localparam logic LAST_RST  = REQ_BR;

endpackage

// File: rtl/ext_arbiter_ext.sv
// Immediate extend unit: zero- or sign-extends an n-bit value to 32 bits.
// Purely combinational; the arbiter registers its result.
module ext_arbiter_ext
  import ext_arbiter_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic          ext_op,
  input  logic [n-1:0]  in,
  output logic [31:0]   out
);

  logic fill;

  // Upper bits copy the immediate's top bit only in sign-extend mode.
  always_comb begin
    fill = (ext_op == EXT_SIGN) && in[n-1];
    out  = {{(32-n){fill}}, in};
  end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one extend unit between the ALU immediate
// path and the branch-offset path, with a registered valid/ready output.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          ext_op0,
  input  logic [N-1:0]  imm0,
  input  logic          req1,
  input  logic          ext_op1,
  input  logic [N-1:0]  imm1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          out_valid,
  output logic          out_id,
  output logic [31:0]   out,
  input  logic          out_ready
);

  logic          out_valid_q, out_valid_d;
  logic          out_id_q, out_id_d;
  logic [31:0]   out_q, out_d;
  logic          last_gnt_q, last_gnt_d;

  logic          can_accept;
  logic          gnt0_c, gnt1_c;
  logic          any_gnt;
  logic          sel_op;
  logic [N-1:0]  sel_imm;
  logic [31:0]   ext_res;

  assign can_accept = !out_valid_q || out_ready;
  assign any_gnt    = gnt0_c || gnt1_c;

  // Grant decision: lone requester wins, contention goes to the one
  // not served last; nothing is granted in reset or while stalled.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset && can_accept) begin
      unique case (1'b1)
        (req0 && !req1): gnt0_c = 1'b1;
        (req1 && !req0): gnt1_c = 1'b1;
        (req0 && req1): begin
          if (last_gnt_q == REQ_BR) gnt0_c = 1'b1;
          else                      gnt1_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Steer the granted requester's operands into the shared extend unit.
  always_comb begin
    sel_op  = gnt1_c ? ext_op1 : ext_op0;
    sel_imm = gnt1_c ? imm1 : imm0;
  end

  ext_arbiter_ext #(
    .n (N)
  ) u_ext (
    .ext_op (sel_op),
    .in     (sel_imm),
    .out    (ext_res)
  );

  // Output slot next state: load on grant, empty on bare transfer,
  // otherwise hold (covers the backpressure freeze).
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_d       = out_q;
    last_gnt_d  = last_gnt_q;
    if (any_gnt) begin
      out_valid_d = 1'b1;
      out_id_d    = gnt1_c ? REQ_BR : REQ_ALU;
      out_d       = ext_res;
      last_gnt_d  = gnt1_c ? REQ_BR : REQ_ALU;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_id_q    <= REQ_ALU;
      out_q       <= '0;
      last_gnt_q  <= LAST_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_q       <= out_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out       = out_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: directed scenarios then random traffic,
// plus a narrow-width instance for the 8-bit sign boundary.
module tb_ext_arbiter;

  localparam int N = 16;

  typedef struct {
    logic        id;
    logic [31:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, ext_op0 = 1'b0, req1 = 1'b0, ext_op1 = 1'b0;
  logic [N-1:0]  imm0 = '0, imm1 = '0;
  logic          gnt0, gnt1, out_valid, out_id, out_ready = 1'b0;
  logic [31:0]   out;

  logic          req0_8 = 1'b0, ext_op0_8 = 1'b0;
  logic          req1_8 = 1'b0, ext_op1_8 = 1'b0;
  logic [7:0]    imm0_8 = '0, imm1_8 = '0;
  logic          gnt0_8, gnt1_8, out_valid_8, out_id_8;
  logic          out_ready_8 = 1'b1;
  logic [31:0]   out_8;

  int            vectors = 0;
  int            miscompares = 0;

  exp_t          sbq[$];
  logic          ref_valid = 1'b0;
  logic          ref_last = 1'b1;

  always #5 clk = ~clk;

  ext_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .ext_op0(ext_op0), .imm0(imm0),
    .req1(req1), .ext_op1(ext_op1), .imm1(imm1),
    .gnt0(gnt0), .gnt1(gnt1),
    .out_valid(out_valid), .out_id(out_id), .out(out),
    .out_ready(out_ready)
  );

  ext_arbiter #(.N(8)) dut8 (
    .clk(clk), .reset(reset),
    .req0(req0_8), .ext_op0(ext_op0_8), .imm0(imm0_8),
    .req1(req1_8), .ext_op1(ext_op1_8), .imm1(imm1_8),
    .gnt0(gnt0_8), .gnt1(gnt1_8),
    .out_valid(out_valid_8), .out_id(out_id_8), .out(out_8),
    .out_ready(out_ready_8)
  );

  function automatic logic [31:0] ref_ext(input logic op,
                                          input logic [N-1:0] imm);
    logic [31:0] v;
    v = 32'(imm);
    if (op && imm[N-1]) v = v | ~((32'd1 << N) - 32'd1);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides grants from the arbitration rules and
  // pushes the expected result for each grant.
  always @(negedge clk) begin
    logic eg0, eg1, can;
    check("out_valid", 32'(out_valid), 32'(ref_valid));
    can = !ref_valid || out_ready;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!reset && can) begin
      if (req0 && req1) begin
        eg0 = (ref_last == 1'b1);
        eg1 = !eg0;
      end else begin
        eg0 = req0;
        eg1 = req1;
      end
    end
    check("gnt0", 32'(gnt0), 32'(eg0));
    check("gnt1", 32'(gnt1), 32'(eg1));
    if (reset) begin
      ref_valid = 1'b0;
      ref_last  = 1'b1;
      sbq.delete();
    end else if (eg0 || eg1) begin
      sbq.push_back('{id: eg1,
                      val: eg1 ? ref_ext(ext_op1, imm1)
                               : ref_ext(ext_op0, imm0)});
      ref_valid = 1'b1;
      ref_last  = eg1;
    end else if (ref_valid && out_ready) begin
      ref_valid = 1'b0;
    end
  end

  // Monitor: compares the presented result with the scoreboard head,
  // retiring it on transfer.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got id=%0d out=%h expected none",
                 out_id, out);
      end else begin
        check("out", out, sbq[0].val);
        check("out_id", 32'(out_id), 32'(sbq[0].id));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic drive(input logic rst,
                       input logic r0, input logic o0, input logic [N-1:0] i0,
                       input logic r1, input logic o1, input logic [N-1:0] i1,
                       input logic rdy);
    @(posedge clk);
    #1;
    reset = rst;
    req0 = r0; ext_op0 = o0; imm0 = i0;
    req1 = r1; ext_op1 = o1; imm1 = i1;
    out_ready = rdy;
  endtask

  task automatic next_req(input logic r_in, input logic g,
                          input logic o_in, input logic [N-1:0] i_in,
                          output logic r, output logic o,
                          output logic [N-1:0] i);
    r = r_in;
    o = o_in;
    i = i_in;
    if (r_in && !g) begin
      if ($urandom_range(0, 9) == 0) r = 1'b0;
    end else begin
      r = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      i = N'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1, r0, o0, r1, o1, rst;
    logic [N-1:0] i0, i1;

    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    drive(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    @(negedge clk);
    check("rst_out", out, 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);

    drive(0, 1, 1, 16'h8000, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 1, 0, 16'h8000, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);

    repeat (4) drive(0, 1, 0, 16'h1234, 1, 1, 16'h8001, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);

    drive(0, 1, 0, 16'h1111, 0, 0, 16'h0, 1);
    repeat (3) drive(0, 1, 0, 16'h2222, 0, 0, 16'h0, 0);
    drive(0, 1, 0, 16'h2222, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);

    drive(0, 1, 1, 16'h7FFF, 0, 0, 16'h0, 1);
    drive(0, 1, 1, 16'hFFFF, 0, 0, 16'h0, 1);
    drive(0, 1, 0, 16'hFFFF, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);

    drive(0, 1, 0, 16'h0055, 1, 0, 16'h0066, 0);
    drive(0, 1, 0, 16'h0077, 1, 0, 16'h0066, 0);
    drive(1, 1, 0, 16'h0077, 1, 0, 16'h0066, 0);
    drive(0, 1, 0, 16'h0077, 1, 0, 16'h0066, 1);
    drive(0, 0, 0, 16'h0, 1, 0, 16'h0066, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);

    req0_8 = 1'b1; ext_op0_8 = 1'b1; imm0_8 = 8'h80;
    @(negedge clk);
    check("n8_gnt0", 32'(gnt0_8), 32'h1);
    @(posedge clk);
    #1;
    imm0_8 = 8'h7F;
    @(negedge clk);
    check("n8_valid", 32'(out_valid_8), 32'h1);
    check("n8_sign", out_8, 32'hFFFFFF80);
    @(posedge clk);
    #1;
    req0_8 = 1'b0;
    @(negedge clk);
    check("n8_pos", out_8, 32'h0000007F);

    r0 = 0; o0 = 0; i0 = '0; r1 = 0; o1 = 0; i1 = '0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
      next_req(r0, g0, o0, i0, r0, o0, i0);
      next_req(r1, g1, o1, i1, r1, o1, i1);
      rst = ($urandom_range(0, 59) == 0);
      drive(rst, r0, o0, i0, r1, o1, i1,
            ($urandom_range(0, 9) < 7));
    end
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
